// File: rtl/dbus_pkg.sv
// Shared types, default constants and access-legality helpers for the data-bus bridge.
package dbus_pkg;

    localparam int          DBUS_XLEN        = 32;
    localparam logic [31:0] DEF_RAM_BASE     = 32'h1000_0000;
    localparam int          DEF_RAM_AW       = 16;
    localparam logic [31:0] DEF_PER_BASE     = 32'h2000_0000;
    localparam int          DEF_PER_AW       = 16;
    localparam int          DEF_TIMEOUT      = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAM_ISSUE = 3'd1,
        ST_RAM_WAIT  = 3'd2,
        ST_PER_WAIT  = 3'd3,
        ST_RESP      = 3'd4
    } dbus_state_t;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_PER  = 2'd2
    } dbus_region_t;

    // Halfwords must sit on a halfword boundary, words on a word boundary.
    function automatic logic byteen_legal(input logic [1:0] off, input logic [3:0] byteen);
        logic ok;
        case (byteen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
            4'b0011:                            ok = (off == 2'd0);
            4'b1100:                            ok = (off == 2'd2);
            4'b1111:                            ok = (off == 2'd0);
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [DBUS_XLEN-1:0] lane_mask(input logic [DBUS_XLEN/8-1:0] byteen);
        logic [DBUS_XLEN-1:0] m;
        m = '0;
        for (int i = 0; i < DBUS_XLEN/8; i++) begin
            m[i*8 +: 8] = {8{byteen[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dbus_decode.sv
// Combinational address/lane decode: which region is hit and whether the lane pattern is illegal.
module dbus_decode
    import dbus_pkg::*;
#(
    parameter int             XLEN     = DBUS_XLEN,
    parameter logic [XLEN-1:0] RAM_BASE = DEF_RAM_BASE,
    parameter int             RAM_AW   = DEF_RAM_AW,
    parameter logic [XLEN-1:0] PER_BASE = DEF_PER_BASE,
    parameter int             PER_AW   = DEF_PER_AW
) (
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN/8-1:0] byteen,
    output dbus_region_t      region,
    output logic              illegal
);

    logic ram_hit;
    logic per_hit;

    assign ram_hit = (addr[XLEN-1:RAM_AW] == RAM_BASE[XLEN-1:RAM_AW]);
    assign per_hit = (addr[XLEN-1:PER_AW] == PER_BASE[XLEN-1:PER_AW]);
    assign illegal = !byteen_legal(addr[1:0], byteen);

    // RAM wins if the two windows are ever configured to overlap.
    always_comb begin
        region = REGION_NONE;
        if (ram_hit) begin
            region = REGION_RAM;
        end else if (per_hit) begin
            region = REGION_PER;
        end else begin
            region = REGION_NONE;
        end
    end

endmodule

// File: rtl/dbus_bridge.sv
// Core data-bus bridge: routes one load/store at a time to a fixed-latency RAM or a timed req/ack peripheral.
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter int              XLEN     = DBUS_XLEN,
    parameter logic [XLEN-1:0] RAM_BASE = DEF_RAM_BASE,
    parameter int              RAM_AW   = DEF_RAM_AW,
    parameter logic [XLEN-1:0] PER_BASE = DEF_PER_BASE,
    parameter int              PER_AW   = DEF_PER_AW,
    parameter int              TIMEOUT  = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN/8-1:0] mem_byteen,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic              mem_ready,
    output logic              mem_rvalid,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              mem_err,
    output logic              ram_req,
    output logic              ram_we,
    output logic [RAM_AW-3:0] ram_addr,
    output logic [XLEN/8-1:0] ram_byteen,
    output logic [XLEN-1:0]   ram_wdata,
    input  logic [XLEN-1:0]   ram_rdata,
    output logic              per_req,
    output logic              per_we,
    output logic [PER_AW-1:0] per_addr,
    output logic [XLEN/8-1:0] per_byteen,
    output logic [XLEN-1:0]   per_wdata,
    input  logic              per_ack,
    input  logic [XLEN-1:0]   per_rdata,
    input  logic              per_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    dbus_state_t       state;
    logic              we_r;
    logic [XLEN/8-1:0] byteen_r;
    logic [7:0]        cnt;
    logic [7:0]        cnt_inc;
    dbus_region_t      region;
    logic              illegal;

    assign cnt_inc = cnt + 8'd1;

    dbus_decode #(
        .XLEN     (XLEN),
        .RAM_BASE (RAM_BASE),
        .RAM_AW   (RAM_AW),
        .PER_BASE (PER_BASE),
        .PER_AW   (PER_AW)
    ) u_decode (
        .addr    (mem_addr),
        .byteen  (mem_byteen),
        .region  (region),
        .illegal (illegal)
    );

    // Request FSM; every core- and bus-facing output is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            we_r       <= 1'b0;
            byteen_r   <= '0;
            cnt        <= 8'd0;
            mem_ready  <= 1'b1;
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            mem_err    <= 1'b0;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_byteen <= '0;
            ram_wdata  <= '0;
            per_req    <= 1'b0;
            per_we     <= 1'b0;
            per_addr   <= '0;
            per_byteen <= '0;
            per_wdata  <= '0;
        end else begin
            ram_req    <= 1'b0;
            mem_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        we_r      <= mem_we;
                        byteen_r  <= mem_byteen;
                        mem_ready <= 1'b0;
                        if (illegal || (region == REGION_NONE)) begin
                            mem_rvalid <= 1'b1;
                            mem_err    <= 1'b1;
                            mem_rdata  <= '0;
                            state      <= ST_RESP;
                        end else if (region == REGION_RAM) begin
                            ram_req    <= 1'b1;
                            ram_we     <= mem_we;
                            ram_addr   <= mem_addr[RAM_AW-1:2];
                            ram_byteen <= mem_byteen;
                            ram_wdata  <= mem_wdata;
                            state      <= ST_RAM_ISSUE;
                        end else begin
                            per_req    <= 1'b1;
                            per_we     <= mem_we;
                            per_addr   <= mem_addr[PER_AW-1:0];
                            per_byteen <= mem_byteen;
                            per_wdata  <= mem_wdata;
                            state      <= ST_PER_WAIT;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RAM_ISSUE: begin
                    state <= ST_RAM_WAIT;
                end
                ST_RAM_WAIT: begin
                    mem_rvalid <= 1'b1;
                    mem_err    <= 1'b0;
                    mem_rdata  <= we_r ? '0 : (ram_rdata & lane_mask(byteen_r));
                    state      <= ST_RESP;
                end
                ST_PER_WAIT: begin
                    // An ack in the final allowed cycle still counts as a completion.
                    if (per_ack) begin
                        per_req    <= 1'b0;
                        cnt        <= 8'd0;
                        mem_rvalid <= 1'b1;
                        mem_err    <= per_err;
                        mem_rdata  <= per_rdata & lane_mask(byteen_r);
                        state      <= ST_RESP;
                    end else if (cnt_inc == TIMEOUT_CNT) begin
                        per_req    <= 1'b0;
                        cnt        <= 8'd0;
                        mem_rvalid <= 1'b1;
                        mem_err    <= 1'b1;
                        mem_rdata  <= '0;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_RESP: begin
                    mem_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    mem_ready <= 1'b1;
                    per_req   <= 1'b0;
                    cnt       <= 8'd0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_bridge.sv
// Scoreboard bench for dbus_bridge: expected responses queued at issue, compared when mem_rvalid fires.
module tb_dbus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        ram_req;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        per_req;
    logic        per_we;
    logic [15:0] per_addr;
    logic [3:0]  per_byteen;
    logic [31:0] per_wdata;
    logic        per_ack;
    logic [31:0] per_rdata;
    logic        per_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_resp   = 0;
    int          n_pushed = 0;
    logic [31:0] ram_value = 32'h0;

    always #5 clk = ~clk;

    dbus_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_byteen (mem_byteen),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err),
        .ram_req    (ram_req),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_byteen (ram_byteen),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .per_req    (per_req),
        .per_we     (per_we),
        .per_addr   (per_addr),
        .per_byteen (per_byteen),
        .per_wdata  (per_wdata),
        .per_ack    (per_ack),
        .per_rdata  (per_rdata),
        .per_err    (per_err)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RAM model: data only valid in the cycle after ram_req, garbage otherwise.
    always @(posedge clk) begin
        ram_rdata <= ram_req ? ram_value : 32'hBAD0_BAD0;
    end

    // Scoreboard: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && mem_rvalid) begin
            n_resp++;
            if (sb_q.size() == 0) begin
                check_value("sb_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = sb_q.pop_front();
                check_value("sb_rdata", mem_rdata, e.rdata);
                check_value("sb_err", {31'd0, mem_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic err);
        resp_t e;
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
        n_pushed++;
    endtask

    // Presents a request and returns #1 into cycle N+1.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        mem_req    = 1'b1;
        mem_we     = we;
        mem_addr   = addr;
        mem_byteen = be;
        mem_wdata  = wd;
        @(negedge clk);
        check_value("issue_ready", {31'd0, mem_ready}, 32'd1);
        @(posedge clk);
        #1;
        mem_req = 1'b0;
    endtask

    task automatic ram_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] rv, input logic [31:0] exp_rd,
                           input logic [13:0] exp_waddr, input logic hold_req);
        ram_value = rv;
        push_exp(exp_rd, 1'b0);
        issue(we, addr, be, wd);
        if (hold_req) begin
            mem_req  = 1'b1;
            mem_addr = 32'h2000_0000;
        end
        @(negedge clk);
        check_value("ram_req_n1", {31'd0, ram_req}, 32'd1);
        check_value("ram_addr", {18'd0, ram_addr}, {18'd0, exp_waddr});
        check_value("ram_we", {31'd0, ram_we}, {31'd0, we});
        check_value("ram_byteen", {28'd0, ram_byteen}, {28'd0, be});
        check_value("ram_wdata", ram_wdata, wd);
        check_value("ram_busy_n1", {31'd0, mem_ready}, 32'd0);
        next_cycle();
        @(negedge clk);
        check_value("ram_req_n2", {31'd0, ram_req}, 32'd0);
        check_value("ram_rvalid_n2", {31'd0, mem_rvalid}, 32'd0);
        next_cycle();
        mem_req = 1'b0;
        @(negedge clk);
        check_value("ram_rvalid_n3", {31'd0, mem_rvalid}, 32'd1);
        check_value("ram_busy_n3", {31'd0, mem_ready}, 32'd0);
        next_cycle();
        @(negedge clk);
        check_value("ram_rvalid_n4", {31'd0, mem_rvalid}, 32'd0);
        check_value("ram_ready_n4", {31'd0, mem_ready}, 32'd1);
        check_value("ram_no_per", {31'd0, per_req}, 32'd0);
        next_cycle();
    endtask

    // Ack arrives in cycle N+waits+1.
    task automatic per_txn(input logic [31:0] addr, input logic [3:0] be, input int waits,
                           input logic [31:0] ack_rd, input logic ack_err, input logic [31:0] exp_rd);
        int hi;
        hi = 0;
        push_exp(exp_rd, ack_err);
        issue(1'b0, addr, be, 32'h0);
        for (int k = 0; k < waits; k++) begin
            @(negedge clk);
            if (per_req && !mem_ready && !mem_rvalid) hi++;
            next_cycle();
        end
        per_ack   = 1'b1;
        per_rdata = ack_rd;
        per_err   = ack_err;
        @(negedge clk);
        if (per_req && !mem_ready && !mem_rvalid) hi++;
        check_value("per_addr", {16'd0, per_addr}, {16'd0, addr[15:0]});
        check_value("per_byteen", {28'd0, per_byteen}, {28'd0, be});
        check_value("per_req_cycles", hi, waits + 1);
        next_cycle();
        per_ack   = 1'b0;
        per_rdata = 32'h0;
        per_err   = 1'b0;
        @(negedge clk);
        check_value("per_rvalid_after_ack", {31'd0, mem_rvalid}, 32'd1);
        check_value("per_req_dropped", {31'd0, per_req}, 32'd0);
        next_cycle();
        @(negedge clk);
        check_value("per_ready_back", {31'd0, mem_ready}, 32'd1);
        next_cycle();
    endtask

    task automatic dec_err_txn(input logic [31:0] addr, input logic [3:0] be);
        push_exp(32'h0, 1'b1);
        issue(1'b0, addr, be, 32'h1234_5678);
        @(negedge clk);
        check_value("dec_rvalid_n1", {31'd0, mem_rvalid}, 32'd1);
        check_value("dec_no_ram", {31'd0, ram_req}, 32'd0);
        check_value("dec_no_per", {31'd0, per_req}, 32'd0);
        next_cycle();
        @(negedge clk);
        check_value("dec_ready_n2", {31'd0, mem_ready}, 32'd1);
        check_value("dec_rvalid_n2", {31'd0, mem_rvalid}, 32'd0);
        next_cycle();
    endtask

    initial begin
        int hi;
        int rv_seen;
        rst        = 1'b1;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_byteen = 4'h0;
        mem_wdata  = 32'h0;
        per_ack    = 1'b0;
        per_rdata  = 32'h0;
        per_err    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_value("rst_ready", {31'd0, mem_ready}, 32'd1);
        check_value("rst_rvalid", {31'd0, mem_rvalid}, 32'd0);
        check_value("rst_err", {31'd0, mem_err}, 32'd0);
        check_value("rst_rdata", mem_rdata, 32'h0);
        check_value("rst_ram_req", {31'd0, ram_req}, 32'd0);
        check_value("rst_ram_addr", {18'd0, ram_addr}, 32'd0);
        check_value("rst_per_req", {31'd0, per_req}, 32'd0);
        check_value("rst_per_addr", {16'd0, per_addr}, 32'd0);
        next_cycle();

        ram_txn(1'b0, 32'h1000_0010, 4'b1111, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 14'h0004, 1'b0);
        ram_txn(1'b1, 32'h1000_0003, 4'b1000, 32'hAA00_0000, 32'h5555_5555, 32'h0, 14'h0000, 1'b1);
        ram_txn(1'b0, 32'h1000_0022, 4'b1100, 32'h0, 32'h1122_3344, 32'h1122_0000, 14'h0008, 1'b0);
        ram_txn(1'b0, 32'h1000_FFFC, 4'b0010, 32'h0, 32'hA5A5_5A5A, 32'h0000_5A00, 14'h3FFF, 1'b0);

        per_txn(32'h2000_0008, 4'b1111, 3, 32'h1234_5678, 1'b0, 32'h1234_5678);
        per_txn(32'h2000_0002, 4'b1100, 15, 32'hCAFE_BABE, 1'b1, 32'hCAFE_0000);

        // Timeout: per_req held exactly 16 cycles, then an error response.
        push_exp(32'h0, 1'b1);
        issue(1'b0, 32'h2000_0100, 4'b1111, 32'h0);
        hi = 0;
        rv_seen = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (per_req) hi++;
            if (mem_rvalid) rv_seen++;
            next_cycle();
        end
        check_value("to_per_req_cycles", hi, 32'd16);
        check_value("to_early_rvalid", rv_seen, 32'd0);
        @(negedge clk);
        check_value("to_per_req_dropped", {31'd0, per_req}, 32'd0);
        check_value("to_rvalid_n17", {31'd0, mem_rvalid}, 32'd1);
        next_cycle();
        per_ack   = 1'b1;
        per_rdata = 32'hFFFF_FFFF;
        per_err   = 1'b1;
        next_cycle();
        per_ack   = 1'b0;
        per_rdata = 32'h0;
        per_err   = 1'b0;
        rv_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_rvalid || per_req || !mem_ready) rv_seen++;
            next_cycle();
        end
        check_value("late_ack_ignored", rv_seen, 32'd0);

        dec_err_txn(32'h3000_0000, 4'b1111);
        dec_err_txn(32'h1000_0001, 4'b0011);
        dec_err_txn(32'h1000_0000, 4'b0000);
        dec_err_txn(32'h2000_0002, 4'b1111);

        // Reset during a peripheral wait abandons the request silently.
        issue(1'b0, 32'h2000_0004, 4'b1111, 32'h0);
        @(negedge clk);
        check_value("mid_rst_per_req", {31'd0, per_req}, 32'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_value("mid_rst_per_drop", {31'd0, per_req}, 32'd0);
        check_value("mid_rst_ready", {31'd0, mem_ready}, 32'd1);
        rv_seen = 0;
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            @(negedge clk);
            if (mem_rvalid || per_req) rv_seen++;
        end
        check_value("mid_rst_no_resp", rv_seen, 32'd0);
        next_cycle();

        ram_txn(1'b0, 32'h1000_0100, 4'b0001, 32'h0, 32'h0102_0304, 32'h0000_0004, 14'h0040, 1'b0);

        check_value("sb_drained", sb_q.size(), 32'd0);
        check_value("sb_resp_count", n_resp, n_pushed);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
- Sits directly downstream of the core's data-memory interface.
- Accepts one load/store request at a time and decodes its address into a RAM region or a peripheral region.
- Drives a fixed-latency RAM port, or a req/ack peripheral port guarded by a timeout.
- Returns read data and an error flag to the core. Adds a ready/response handshake so the core can stall on slow peripherals.

Parameters:
- XLEN, 32, data/address width (from core_config_pkg).
- RAM_BASE, 32'h1000_0000, RAM region base; must be aligned to 2**RAM_AW.
- RAM_AW, 16, log2 of RAM region size in bytes.
- PER_BASE, 32'h2000_0000, peripheral region base; must be aligned to 2**PER_AW.
- PER_AW, 16, log2 of peripheral region size in bytes.
- TIMEOUT, 16, cycles a peripheral request may wait for ack before erroring (range 1..255).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- mem_req  in  1  core request strobe, sampled only when mem_ready=1.
- mem_we  in  1  1=store, 0=load.
- mem_addr  in  XLEN  byte address.
- mem_byteen  in  XLEN/8  byte-lane enables.
- mem_wdata  in  XLEN  store data.
- mem_ready  out  1  bridge idle, can accept a request.
- mem_rvalid  out  1  one-cycle response strobe.
- mem_rdata  out  XLEN  load data, valid with mem_rvalid.
- mem_err  out  1  error flag, valid with mem_rvalid.
- ram_req  out  1  RAM access strobe, one cycle.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW-2  RAM word address.
- ram_byteen  out  XLEN/8  RAM byte enables.
- ram_wdata  out  XLEN  RAM write data.
- ram_rdata  in  XLEN  RAM read data, valid the cycle after ram_req.
- per_req  out  1  peripheral request, held until ack or timeout.
- per_we  out  1  peripheral write.
- per_addr  out  PER_AW  peripheral byte offset.
- per_byteen  out  XLEN/8  peripheral byte enables.
- per_wdata  out  XLEN  peripheral write data.
- per_ack  in  1  peripheral completion, single cycle.
- per_rdata  in  XLEN  peripheral read data, valid with per_ack.
- per_err  in  1  peripheral error, valid with per_ack.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: FSM=IDLE, mem_ready=1, mem_rvalid=0, mem_err=0, mem_rdata=0, all ram_*/per_* outputs=0, timeout counter=0.
- Reset mid-operation: the transaction is abandoned with no response; per_req drops on the cycle after rst is sampled.
- All outputs are registered.
- FSM states: IDLE, RAM_ISSUE, RAM_WAIT, PER_WAIT, RESP.
- IDLE:
  - mem_ready=1.
  - On mem_req: latch we/addr/byteen/wdata and decode.
  - Illegal byteen, or address outside both regions -> RESP with err=1, rdata=0.
  - Legal byteen patterns are 0001, 0010, 0100, 1000, 0011, 1100, 1111. The lane pattern must also match addr[1:0]: single byte any offset; halfword offset 0 or 2; word offset 0. Any other combination is illegal.
  - RAM hit -> RAM_ISSUE. Peripheral hit -> PER_WAIT.
- RAM_ISSUE: ram_req=1 for exactly one cycle, with ram_addr=addr[RAM_AW-1:2]. Next state RAM_WAIT.
- RAM_WAIT: capture ram_rdata and mask disabled lanes to 0 (store: rdata=0). Next state RESP with err=0.
- PER_WAIT:
  - per_req=1 with per_addr=addr[PER_AW-1:0]; the counter increments every cycle.
  - per_ack=1: capture per_rdata (lane-masked) and per_err -> RESP.
  - Counter reaches TIMEOUT with no ack: deassert per_req -> RESP with err=1, rdata=0.
  - per_ack on the same cycle the counter reaches TIMEOUT: ack wins.
  - Counter clears on leaving PER_WAIT.
- RESP: mem_rvalid=1 for exactly one cycle, then IDLE. mem_ready returns to 1 on the cycle after RESP.
- Latency, with request accepted in cycle N:
  - Decode error: mem_rvalid at N+1.
  - RAM: ram_req at N+1, mem_rvalid at N+3.
  - Peripheral acked at cycle K: mem_rvalid at K+1.
  - Peripheral timeout: mem_rvalid at N+1+TIMEOUT.
- mem_req while mem_ready=0 is ignored (the core must not issue).
- A late per_ack outside PER_WAIT is ignored.
- Address decode: hit when addr[XLEN-1:AW] == BASE[XLEN-1:AW]. If the two regions overlap, the RAM region takes priority.
- The bridge is endian-neutral; byte swapping is done in the core.

Decomposition:
- Shared package (dbus_pkg):
  - Typedef dbus_state_t enum for the FSM states.
  - Default base/size constants.
  - Function byteen_legal(addr[1:0], byteen).
  - Function lane_mask(byteen) returning the XLEN mask.
- One natural sub-module: dbus_decode. It is combinational and outputs region hit (RAM/PER/none) and the illegal-access flag; the FSM lives in dbus_bridge.

Test Plan:
- RAM word load: rst 2 cycles; req we=0 addr=0x1000_0010 byteen=1111, ram_rdata=0xDEADBEEF -> ram_req N+1 with ram_addr=0x0004; rvalid N+3, rdata=0xDEADBEEF, err=0.
- RAM byte store: addr=0x1000_0003 byteen=1000 wdata=0xAA000000 -> ram_we=1, ram_byteen=1000, ram_wdata passthrough; rvalid N+3, rdata=0, err=0.
- Peripheral with ack after 3 wait cycles: addr=0x2000_0008 load, per_ack with rdata=0x12345678 and per_err=0 -> per_req high 4 cycles; rvalid the cycle after ack, rdata=0x12345678; mem_ready low throughout.
- Peripheral timeout: TIMEOUT=16, per_ack never asserted -> per_req drops after 16 cycles; rvalid with err=1, rdata=0; a late per_ack afterwards has no effect.
- Decode errors, each -> rvalid N+1 with err=1 and no ram_req/per_req:
  - addr=0x3000_0000 (unmapped).
  - addr=0x1000_0001 with byteen=0011 (misaligned halfword).
  - byteen=0000.
- Reset mid-peripheral wait: assert rst while per_req=1 -> next cycle per_req=0, mem_ready=1, and no rvalid ever appears for the abandoned request.
